decode_execute_reg: RTL and testbench
=====================================

# decode_execute_reg

Decode→Execute pipeline register with integrated load-use hazard detection and branch flush control. It captures decoded operands, register indices and control from the Decode stage. It presents the E-stage values (RS1_E, RS2_E, RD_E, RegWriteE, …) consumed by the forwarding unit and the ALU. It also generates the stall and flush strobes for the Fetch/Decode registers and keeps saturating bubble counters for performance monitoring.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of each performance counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- RS1_D, RS2_D, RD_D  in  5 each  decoded register indices
- RD1_D, RD2_D, Imm_Ext_D, PC_D, PCPlus4_D  in  XLEN each  decoded operands and PCs
- RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD  in  1 each  decoded controls
- ResultSrcD  in  2  00 ALU, 01 memory (load), 10 PC+4
- ALUControlD  in  3  ALU operation
- ValidD  in  1  Decode holds a real instruction
- PCSrcE  in  1  taken branch/jump resolved in Execute this cycle
- ExtStall  in  1  global hold, for example a memory wait
- RS1_E, RS2_E, RD_E  out  5 each  registered indices
- RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E  out  XLEN each  registered operands
- RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  out  1 each  registered controls
- ResultSrcE  out  2  registered control
- ALUControlE  out  3  registered control
- ValidE  out  1  Execute holds a real instruction
- StallF, StallD  out  1 each  hold the PC and IF/ID registers
- FlushD  out  1  clear the IF/ID register
- BubbleCnt, FlushCnt  out  CNT_W each  saturating event counters

## Operation
- Load-use detect, combinational:
  - LwStall = ValidE & RegWriteE & (ResultSrcE==01) & (RD_E!=0) & ValidD & ((RS1_D==RD_E) | (RS2_D==RD_E)).
- Strobes, combinational:
  - StallF = StallD = LwStall | ExtStall.
  - FlushD = PCSrcE & ~ExtStall.
  - FlushE (internal) = (LwStall | PCSrcE) & ~ExtStall.
- Register update at each rising clk, first matching rule wins:
  1. rst==0: every E output and both counters become 0.
  2. ExtStall==1: all E registers and both counters hold.
  3. FlushE==1: insert a bubble.
     - Every E output becomes 0, including RD_E, RS1_E and RS2_E. This means downstream forwarding never matches the bubble.
     - ValidE becomes 0.
  4. Otherwise: every E output takes its D input, and ValidE takes ValidD.
- Counters, updated only under rule 3:
  - BubbleCnt increments when LwStall=1 (also when PCSrcE=1 in the same cycle).
  - FlushCnt increments when PCSrcE=1.
  - Each counter saturates at 2^CNT_W−1 and does not wrap.
- A simultaneous LwStall and PCSrcE is a single flush of E. FlushD also asserts, so the stalled D instruction is killed. This is correct: it lies on the wrong path.
- Destination x0 never triggers LwStall.
- A load with RegWriteE=0 never triggers LwStall.
- An invalid D slot (ValidD=0) never triggers LwStall.
- Arithmetic: indices are compared as 5-bit equality; the counters are unsigned CNT_W-bit.

## Timing
- Latency: D inputs appear on the E outputs 1 cycle after a capturing edge.
- StallF, StallD and FlushD are combinational, valid in the same cycle as the E state and D inputs that cause them. There is no registered delay.
- Load-use penalty: exactly one bubble.
  - The load sits in E at cycle n, with the dependent instruction in D.
  - At cycle n+1 the load is in M (forwarded via RD_M) and E is a bubble.
  - The dependent instruction, held in D, enters E at cycle n+2 and receives the load result through WB forwarding.
- Branch penalty:
  - PCSrcE at cycle n flushes E and D at edge n+1.
  - Two bubbles are counted in total across stages, but FlushCnt increments once.
- Reset mid-operation: on the first edge with rst=0, all outputs and counters are 0, regardless of ExtStall or PCSrcE. After rst returns high, the first edge captures the D inputs.
- ExtStall overrides flush for the whole cycle it is high. PCSrcE must be held by Execute (E is frozen), so the flush occurs on the first edge after ExtStall drops.

## Test plan
- Load-use:
  - Stimulus: E = lw x5 (RegWriteE=1, ResultSrcE=01, RD_E=5); D has RS1_D=5, ValidD=1.
  - Required: StallF=StallD=1 same cycle; next edge gives ValidE=0, RD_E=0, BubbleCnt=1; the following edge gives RS1_E=5 and ValidE=1.
- x0 and non-load:
  - Stimulus 1: as above with RD_E=0. Required: no stall.
  - Stimulus 2: ResultSrcE=00, RD_E=5, RS2_D=5. Required: no stall; D passes through.
- Branch:
  - Stimulus: PCSrcE=1 with an ALU instruction in D.
  - Required: FlushD=1; next edge gives all E outputs 0, FlushCnt=1, BubbleCnt=0.
- Simultaneous:
  - Stimulus: LwStall and PCSrcE both 1.
  - Required: one bubble; BubbleCnt and FlushCnt each +1; FlushD=1; StallD=1.
- ExtStall:
  - Stimulus: hold ExtStall=1 for 3 cycles with a pending LwStall.
  - Required: E outputs and counters unchanged, StallF=1, FlushD=0; the bubble is inserted on the first edge after release.
- Reset and saturation:
  - Stimulus 1: assert rst=0 mid-stream with ExtStall=1. Required: all outputs 0 after one edge.
  - Stimulus 2: preload BubbleCnt near 0xFFFF (CNT_W=16) and force further load-use events. Required: BubbleCnt stays at 0xFFFF.

Source files
------------

// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register with load-use stall detection, branch flush
// strobes and saturating bubble/flush event counters.
module decode_execute_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RD_D,
  input  logic [XLEN-1:0]  RD1_D,
  input  logic [XLEN-1:0]  RD2_D,
  input  logic [XLEN-1:0]  Imm_Ext_D,
  input  logic [XLEN-1:0]  PC_D,
  input  logic [XLEN-1:0]  PCPlus4_D,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic             ValidD,
  input  logic             PCSrcE,
  input  logic             ExtStall,
  output logic [4:0]       RS1_E,
  output logic [4:0]       RS2_E,
  output logic [4:0]       RD_E,
  output logic [XLEN-1:0]  RD1_E,
  output logic [XLEN-1:0]  RD2_E,
  output logic [XLEN-1:0]  Imm_Ext_E,
  output logic [XLEN-1:0]  PC_E,
  output logic [XLEN-1:0]  PCPlus4_E,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             BranchE,
  output logic             JumpE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic             ValidE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic [CNT_W-1:0] BubbleCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             lw_stall;
  logic             flush_e;
  logic [CNT_W-1:0] bubble_cnt_next;
  logic [CNT_W-1:0] flush_cnt_next;

  // A load in E whose destination feeds the instruction waiting in D.
  assign lw_stall = ValidE & RegWriteE & (ResultSrcE == 2'b01) & (RD_E != 5'd0) &
                    ValidD & ((RS1_D == RD_E) | (RS2_D == RD_E));

  assign StallF  = lw_stall | ExtStall;
  assign StallD  = lw_stall | ExtStall;
  assign FlushD  = PCSrcE & ~ExtStall;
  assign flush_e = (lw_stall | PCSrcE) & ~ExtStall;

  always_comb begin
    bubble_cnt_next = BubbleCnt;
    flush_cnt_next  = FlushCnt;
    if (lw_stall && (BubbleCnt != CNT_MAX)) bubble_cnt_next = BubbleCnt + 1'b1;
    if (PCSrcE && (FlushCnt != CNT_MAX))    flush_cnt_next  = FlushCnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      RS1_E       <= '0;
      RS2_E       <= '0;
      RD_E        <= '0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      PC_E        <= '0;
      PCPlus4_E   <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      ValidE      <= 1'b0;
      BubbleCnt   <= '0;
      FlushCnt    <= '0;
    end else if (ExtStall) begin
      // Whole E stage and counters are frozen.
    end else if (flush_e) begin
      // Bubble clears indices too so forwarding can never match it.
      RS1_E       <= '0;
      RS2_E       <= '0;
      RD_E        <= '0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      PC_E        <= '0;
      PCPlus4_E   <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      ValidE      <= 1'b0;
      BubbleCnt   <= bubble_cnt_next;
      FlushCnt    <= flush_cnt_next;
    end else begin
      RS1_E       <= RS1_D;
      RS2_E       <= RS2_D;
      RD_E        <= RD_D;
      RD1_E       <= RD1_D;
      RD2_E       <= RD2_D;
      Imm_Ext_E   <= Imm_Ext_D;
      PC_E        <= PC_D;
      PCPlus4_E   <= PCPlus4_D;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      ALUSrcE     <= ALUSrcD;
      BranchE     <= BranchD;
      JumpE       <= JumpD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
      ValidE      <= ValidD;
    end
  end

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for decode_execute_reg; a second instance with 3-bit counters
// shares the stimulus so counter saturation is reached in a few events.
module tb_decode_execute_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RS1_D, RS2_D, RD_D;
  logic [31:0] RD1_D, RD2_D, Imm_Ext_D, PC_D, PCPlus4_D;
  logic        RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic        ValidD, PCSrcE, ExtStall;

  logic [4:0]  RS1_E, RS2_E, RD_E;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic        ValidE, StallF, StallD, FlushD;
  logic [15:0] BubbleCnt, FlushCnt;

  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [31:0] s_rd1, s_rd2, s_imm, s_pc, s_pc4;
  logic        s_rw, s_mw, s_alusrc, s_br, s_jmp;
  logic [1:0]  s_rsrc;
  logic [2:0]  s_aluc;
  logic        s_valid, s_stallf, s_stalld, s_flushd;
  logic [2:0]  s_bcnt, s_fcnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_execute_reg #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .Imm_Ext_D(Imm_Ext_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .BranchD(BranchD),
    .JumpD(JumpD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .ValidD(ValidD),
    .PCSrcE(PCSrcE), .ExtStall(ExtStall),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
    .JumpE(JumpE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .ValidE(ValidE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BubbleCnt(BubbleCnt), .FlushCnt(FlushCnt)
  );

  decode_execute_reg #(.XLEN(32), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .Imm_Ext_D(Imm_Ext_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .BranchD(BranchD),
    .JumpD(JumpD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .ValidD(ValidD),
    .PCSrcE(PCSrcE), .ExtStall(ExtStall),
    .RS1_E(s_rs1), .RS2_E(s_rs2), .RD_E(s_rd),
    .RD1_E(s_rd1), .RD2_E(s_rd2), .Imm_Ext_E(s_imm), .PC_E(s_pc), .PCPlus4_E(s_pc4),
    .RegWriteE(s_rw), .MemWriteE(s_mw), .ALUSrcE(s_alusrc), .BranchE(s_br),
    .JumpE(s_jmp), .ResultSrcE(s_rsrc), .ALUControlE(s_aluc), .ValidE(s_valid),
    .StallF(s_stallf), .StallD(s_stalld), .FlushD(s_flushd),
    .BubbleCnt(s_bcnt), .FlushCnt(s_fcnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Operands derive from pc: RD1=pc+1, RD2=pc+2, Imm=pc+8, PCPlus4=pc+4.
  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] rsrc, input logic v,
                       input logic [31:0] pc);
    RS1_D = rs1; RS2_D = rs2; RD_D = rd;
    RegWriteD = rw; ResultSrcD = rsrc; ValidD = v;
    PC_D = pc; PCPlus4_D = pc + 32'd4;
    RD1_D = pc + 32'd1; RD2_D = pc + 32'd2; Imm_Ext_D = pc + 32'd8;
    MemWriteD = 1'b0; ALUSrcD = (rsrc == 2'b01); BranchD = 1'b0; JumpD = 1'b0;
    ALUControlD = 3'b110;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ExtStall = 1'b0; PCSrcE = 1'b0;
    set_d(5'd3, 5'd4, 5'd7, 1'b1, 2'b00, 1'b1, 32'h0000_0040);
    step(); step();
    chk("reset_valid", ValidE, 1'b0);
    chk("reset_rd", RD_E, 5'd0);
    chk("reset_pc", PC_E, 32'd0);
    chk("reset_bcnt", BubbleCnt, 16'd0);
    chk("reset_fcnt", FlushCnt, 16'd0);
    chk("reset_stallf", StallF, 1'b0);

    // Load-use: lw x5 enters E, then add x6,x5,x7 waits in D.
    rst = 1'b1;
    set_d(5'd1, 5'd2, 5'd5, 1'b1, 2'b01, 1'b1, 32'h0000_0100);
    step();
    chk("lw_rd_e", RD_E, 5'd5);
    chk("lw_rsrc_e", ResultSrcE, 2'b01);
    chk("lw_rd1_e", RD1_E, 32'h0000_0101);
    chk("lw_pc4_e", PCPlus4_E, 32'h0000_0104);
    chk("lw_valid_e", ValidE, 1'b1);
    set_d(5'd5, 5'd7, 5'd6, 1'b1, 2'b00, 1'b1, 32'h0000_0104);
    #1;
    chk("lu_stallf", StallF, 1'b1);
    chk("lu_stalld", StallD, 1'b1);
    chk("lu_flushd", FlushD, 1'b0);
    step();
    chk("lu_bub_valid", ValidE, 1'b0);
    chk("lu_bub_rd", RD_E, 5'd0);
    chk("lu_bub_rs1", RS1_E, 5'd0);
    chk("lu_bub_rw", RegWriteE, 1'b0);
    chk("lu_bub_pc", PC_E, 32'd0);
    chk("lu_bcnt", BubbleCnt, 16'd1);
    chk("lu_fcnt", FlushCnt, 16'd0);
    chk("lu_stall_clear", StallF, 1'b0);
    step();
    chk("lu_dep_rs1", RS1_E, 5'd5);
    chk("lu_dep_rs2", RS2_E, 5'd7);
    chk("lu_dep_rd", RD_E, 5'd6);
    chk("lu_dep_valid", ValidE, 1'b1);
    chk("lu_dep_rd2", RD2_E, 32'h0000_0106);
    chk("lu_dep_aluc", ALUControlE, 3'b110);

    // Load to x0 never stalls.
    set_d(5'd1, 5'd2, 5'd0, 1'b1, 2'b01, 1'b1, 32'h0000_0200);
    step();
    set_d(5'd0, 5'd0, 5'd5, 1'b1, 2'b00, 1'b1, 32'h0000_0204);
    #1;
    chk("x0_stallf", StallF, 1'b0);
    step();
    chk("x0_pass_rd", RD_E, 5'd5);
    chk("x0_pass_pc", PC_E, 32'h0000_0204);
    // ALU result in E with matching RS2 does not stall.
    set_d(5'd9, 5'd5, 5'd7, 1'b1, 2'b00, 1'b1, 32'h0000_0208);
    #1;
    chk("alu_stalld", StallD, 1'b0);
    step();
    chk("alu_pass_rd", RD_E, 5'd7);
    chk("alu_pass_rs2", RS2_E, 5'd5);
    chk("alu_pass_imm", Imm_Ext_E, 32'h0000_0210);
    chk("alu_bcnt", BubbleCnt, 16'd1);

    // Load without RegWrite, then load with invalid D slot: neither stalls.
    set_d(5'd1, 5'd2, 5'd5, 1'b0, 2'b01, 1'b1, 32'h0000_0300);
    step();
    set_d(5'd5, 5'd5, 5'd8, 1'b1, 2'b00, 1'b1, 32'h0000_0304);
    #1;
    chk("norw_stallf", StallF, 1'b0);
    set_d(5'd1, 5'd2, 5'd5, 1'b1, 2'b01, 1'b1, 32'h0000_0308);
    step();
    set_d(5'd5, 5'd5, 5'd8, 1'b1, 2'b00, 1'b0, 32'h0000_030c);
    #1;
    chk("invd_stallf", StallF, 1'b0);
    step();
    chk("invd_valid_e", ValidE, 1'b0);
    chk("invd_rd_e", RD_E, 5'd8);

    // Taken branch with an ALU instruction in D.
    set_d(5'd1, 5'd2, 5'd8, 1'b1, 2'b00, 1'b1, 32'h0000_0400);
    PCSrcE = 1'b1;
    #1;
    chk("br_flushd", FlushD, 1'b1);
    chk("br_stallf", StallF, 1'b0);
    step();
    PCSrcE = 1'b0;
    chk("br_rd", RD_E, 5'd0);
    chk("br_valid", ValidE, 1'b0);
    chk("br_pc", PC_E, 32'd0);
    chk("br_rw", RegWriteE, 1'b0);
    chk("br_aluc", ALUControlE, 3'b000);
    chk("br_fcnt", FlushCnt, 16'd1);
    chk("br_bcnt", BubbleCnt, 16'd1);

    // Load-use and taken branch in the same cycle: one bubble, both counted.
    set_d(5'd1, 5'd2, 5'd5, 1'b1, 2'b01, 1'b1, 32'h0000_0500);
    step();
    set_d(5'd5, 5'd3, 5'd6, 1'b1, 2'b00, 1'b1, 32'h0000_0504);
    PCSrcE = 1'b1;
    #1;
    chk("sim_flushd", FlushD, 1'b1);
    chk("sim_stalld", StallD, 1'b1);
    step();
    PCSrcE = 1'b0;
    chk("sim_valid", ValidE, 1'b0);
    chk("sim_rd", RD_E, 5'd0);
    chk("sim_bcnt", BubbleCnt, 16'd2);
    chk("sim_fcnt", FlushCnt, 16'd2);

    // External stall held 3 cycles over a pending load-use.
    set_d(5'd1, 5'd2, 5'd5, 1'b1, 2'b01, 1'b1, 32'h0000_0600);
    step();
    set_d(5'd5, 5'd3, 5'd6, 1'b1, 2'b00, 1'b1, 32'h0000_0604);
    ExtStall = 1'b1;
    #1;
    chk("ext_stallf", StallF, 1'b1);
    chk("ext_flushd", FlushD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ext_hold_rd", RD_E, 5'd5);
      chk("ext_hold_pc", PC_E, 32'h0000_0600);
      chk("ext_hold_valid", ValidE, 1'b1);
      chk("ext_hold_bcnt", BubbleCnt, 16'd2);
    end
    ExtStall = 1'b0;
    #1;
    chk("ext_rel_stalld", StallD, 1'b1);
    step();
    chk("ext_bub_valid", ValidE, 1'b0);
    chk("ext_bub_rd", RD_E, 5'd0);
    chk("ext_bub_bcnt", BubbleCnt, 16'd3);
    step();
    chk("ext_dep_rs1", RS1_E, 5'd5);
    chk("ext_dep_pc", PC_E, 32'h0000_0604);

    // Reset mid-stream wins over ExtStall and PCSrcE.
    rst = 1'b0; ExtStall = 1'b1; PCSrcE = 1'b1;
    step();
    chk("mrst_rd", RD_E, 5'd0);
    chk("mrst_rs1", RS1_E, 5'd0);
    chk("mrst_valid", ValidE, 1'b0);
    chk("mrst_pc", PC_E, 32'd0);
    chk("mrst_bcnt", BubbleCnt, 16'd0);
    chk("mrst_fcnt", FlushCnt, 16'd0);
    rst = 1'b1; ExtStall = 1'b0; PCSrcE = 1'b0;
    set_d(5'd11, 5'd12, 5'd10, 1'b1, 2'b00, 1'b1, 32'h0000_0700);
    step();
    chk("post_rst_rd", RD_E, 5'd10);
    chk("post_rst_valid", ValidE, 1'b1);

    // Ten load-use events: 16-bit counter reaches 10, 3-bit counter holds at 7.
    set_d(5'd5, 5'd0, 5'd5, 1'b1, 2'b01, 1'b1, 32'h0000_0800);
    for (int i = 0; i < 10; i++) begin
      step();
      step();
    end
    chk("sat_bcnt16", BubbleCnt, 16'd10);
    chk("sat_bcnt3", s_bcnt, 3'd7);
    chk("sat_fcnt3", s_fcnt, 3'd0);
    step();
    step();
    chk("sat_bcnt3_hold", s_bcnt, 3'd7);
    chk("sat_bcnt16_next", BubbleCnt, 16'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
